// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage datapath.
// Produces per-latch enable/flush for load-use bubbles, branch/jump squash,
// dcache-miss freeze and halt. All latch controls are combinational from
// state + inputs; only the FSM and the perf counters are registered.
// Optional feature macro: HAZARD_PERF_EN builds saturating stall/flush
// counters; when undefined, stall_cnt/flush_cnt are tied to zero.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mem_brtaken,
  input  logic             id_jump,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, HALT = 2'd2} state_t;

  state_t state_q, state_d;

  logic dmiss, adv, load_use;

  // Outstanding dmem access that has not completed freezes the whole pipe.
  assign dmiss    = (mem_dREN | mem_dWEN) & ~dhit;
  assign adv      = ihit & ~dmiss;
  // Register 0 is hardwired zero, so a load into it never creates a hazard.
  assign load_use = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Next-state: halt wins from any live state; dcache wait exits on dhit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (wb_halt) state_d = HALT;
               else if (dmiss) state_d = DWAIT;
      DWAIT:   if (wb_halt) state_d = HALT;
               else if (dhit) state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  // FSM state register; HALT is absorbing until reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Latch controls by priority: halt > freeze > branch > load-use > jump.
  // Flushes only ever assert in an advance cycle; a squash request seen
  // while frozen stays on the inputs and takes effect once adv returns.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    halt        = 1'b0;
    if (!nRST) begin
      halt = 1'b0;
    end else if (state_q == HALT) begin
      halt = 1'b1;
    end else if (adv) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (mem_brtaken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_ev, flush_ev;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign stall_ev = (state_q != HALT) & (~adv | (~mem_brtaken & load_use));
  assign flush_ev = (state_q != HALT) & adv & (mem_brtaken | id_jump);

  // Saturating perf counters for freeze/bubble cycles and squash events.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + ONE;
      if (flush_ev && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + ONE;
    end
  end

  assign stall_cnt = nRST ? stall_cnt_q : '0;
  assign flush_cnt = nRST ? flush_cnt_q : '0;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes the hand-computed
// latch-control vector per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  logic CLK = 1'b0, nRST;
  logic ihit, dhit, mem_dREN, mem_dWEN, ex_memread, mem_brtaken, id_jump, wb_halt;
  logic [REG_W-1:0] ex_rt, id_rs, id_rt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs),
    .id_rt(id_rt), .mem_brtaken(mem_brtaken), .id_jump(id_jump), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 CLK = ~CLK;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halt}
  localparam logic [8:0] ALL0 = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] RUNV = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] JMP  = 9'b1_1_1_1_0_1_0_1_0;
  localparam logic [8:0] HLT  = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct { logic [8:0] v; string name; } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e = sb.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halt};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.v);
      end
    end
  end

  task automatic cyc(input logic [8:0] v, input string name);
    exp_t e;
    e.v = v; e.name = name;
    sb.push_back(e);
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; mem_brtaken = 0; id_jump = 0; wb_halt = 0;
  endtask

  task automatic chk_cnt(input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef, input string name);
    @(negedge CLK);
    checks++;
    if (stall_cnt !== es || flush_cnt !== ef) begin
      errors++;
      $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d expected %0d/%0d", name, stall_cnt, flush_cnt, es, ef);
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    idle(); nRST = 0;
    @(posedge CLK); #1;
    cyc(ALL0, "reset");
    nRST = 1;
    cyc(RUNV, "run");
    ihit = 0;                                   cyc(ALL0, "ihit_low");
    ihit = 1; ex_memread = 1; ex_rt = 8; id_rs = 8; cyc(LU, "loaduse_rs");
    ex_memread = 0;                             cyc(RUNV, "loaduse_clear");
    ex_memread = 1; ex_rt = 0; id_rs = 3;       cyc(RUNV, "zero_reg");
    ex_rt = 9; id_rt = 9;                       cyc(LU, "loaduse_rt");
    idle(); mem_dREN = 1;
    cyc(ALL0, "dmiss1"); cyc(ALL0, "dmiss2"); cyc(ALL0, "dmiss3");
    dhit = 1;                                   cyc(RUNV, "dhit_exit");
    idle();                                     cyc(RUNV, "run_after_dwait");
    mem_brtaken = 1; ex_memread = 1; ex_rt = 4; id_rs = 4; cyc(BR, "branch_vs_lu");
    idle(); id_jump = 1;                        cyc(JMP, "jump");
    idle(); mem_brtaken = 1; ihit = 0;          cyc(ALL0, "branch_frozen");
    ihit = 1;                                   cyc(BR, "branch_released");
    idle(); mem_dWEN = 1;                       cyc(ALL0, "dmiss_wr");
    wb_halt = 1;                                cyc(ALL0, "halt_in_dwait");
    idle();                                     cyc(HLT, "halted");
    ihit = 0;                                   cyc(HLT, "halted_ihit0");
    ihit = 1; mem_brtaken = 1;                  cyc(HLT, "halted_branch");
    idle(); nRST = 0;                           cyc(ALL0, "reset_from_halt");
    nRST = 1;                                   cyc(RUNV, "run_after_halt");
    mem_dREN = 1;                               cyc(ALL0, "dmiss_pre_rst");
    nRST = 0;                                   cyc(ALL0, "reset_in_dwait");
    nRST = 1; mem_dREN = 0;                     cyc(RUNV, "run_after_rst");

    // Counter segment: 2 bubbles + 3 freeze cycles + 1 branch.
    idle(); nRST = 0; cyc(ALL0, "perf_reset");
    nRST = 1; ex_memread = 1; ex_rt = 5; id_rs = 5;
    cyc(LU, "perf_lu1"); cyc(LU, "perf_lu2");
    idle(); mem_dREN = 1;
    cyc(ALL0, "perf_dm1"); cyc(ALL0, "perf_dm2"); cyc(ALL0, "perf_dm3");
    dhit = 1;                cyc(RUNV, "perf_dhit");
    idle(); mem_brtaken = 1; cyc(BR, "perf_branch");
    idle();
`ifdef HAZARD_PERF_EN
    chk_cnt(5, 1, "perf_counts");
`else
    chk_cnt(0, 0, "perf_tied_zero");
`endif

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
